seq_window_ctrl: RTL

Controller that sequences the saturating window timer for the sequence-detection lab. On a start request it pulses the timer's start input and, while the timer runs toward its terminal count, scans a serial bit stream for a fixed pattern and counts matches. When the window closes it reports pass/fail. Sits between the debounced start button and serial source on one side, and the window timer plus LED/display logic on the other.

---
 rtl/seq_pkg.sv | 26 ++
 rtl/seq_shift_match.sv | 56 +++++
 rtl/seq_window_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// ============================================================================
// Module   : seq_pkg
// Purpose  : Shared state encoding and defaults for the sequence window ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      SCAN = 2'd2,
      DONE = 2'd3
   } seq_state_t;

   localparam int         TMR_LIMIT_DEF = 8;
   localparam logic [3:0] PAT_DEF       = 4'b1101;

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/seq_shift_match.sv
// ============================================================================
// Module   : seq_shift_match
// Purpose  : Serial shift register, saturating bit counter and pattern compare.
//            SEQ_OVERLAP_EN selects overlapping detection (default: non-overlap).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_shift_match
   import seq_pkg::*;
#(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = PAT_W'(PAT_DEF)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic shift_en,
   input  logic din,
   output logic match
);

   localparam int               CNT_W   = $clog2(PAT_W + 1);
   localparam logic [CNT_W-1:0] c_pat_w = CNT_W'(PAT_W);
   localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

   logic [PAT_W-1:0] r_shift;
   logic [PAT_W-1:0] w_shift_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_inc;

   // The compare looks at the value the register is about to hold, so the
   // incoming bit takes part in the match on the same edge it is shifted in.
   always_comb begin
      w_shift_next = {r_shift[PAT_W-2:0], din};
      w_cnt_inc    = (r_cnt >= c_pat_w) ? c_pat_w : r_cnt + c_one;
      match        = shift_en && (w_shift_next == PATTERN) && (w_cnt_inc >= c_pat_w);
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (shift_en) begin
         r_shift <= w_shift_next;
`ifdef SEQ_OVERLAP_EN
         r_cnt   <= w_cnt_inc;
`else
         r_cnt   <= match ? '0 : w_cnt_inc;
`endif
      end
   end

endmodule

`default_nettype wire

// File: rtl/seq_window_ctrl.sv
// ============================================================================
// Module   : seq_window_ctrl
// Purpose  : Launches the window timer, counts pattern hits while it runs and
//            reports a pass/fail verdict at expiry. Honours SEQ_OVERLAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_window_ctrl
   import seq_pkg::*;
#(
   parameter int               PAT_W     = 4,
   parameter logic [PAT_W-1:0] PATTERN   = PAT_W'(PAT_DEF),
   parameter int               TMR_LIMIT = TMR_LIMIT_DEF,
   parameter int               HIT_MIN   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       din,
   input  logic       din_vld,
   input  logic [3:0] tmr_num,
   output logic       tmr_start,
   output logic       busy,
   output logic       hit,
   output logic [3:0] win_hits,
   output logic       done,
   output logic       pass
);

   localparam logic [3:0] c_tmr_limit = 4'(TMR_LIMIT);
   localparam logic [3:0] c_hit_min   = 4'(HIT_MIN);

   seq_state_t r_state;
   seq_state_t w_state_next;
   logic       w_launch;
   logic       w_expire;
   logic       w_shift_en;
   logic       w_match;
   logic [3:0] w_hits_next;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_launch     = 1'b0;
      w_expire     = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_launch     = 1'b1;
               w_state_next = ARM;
            end
         end
         ARM:  w_state_next = SCAN;
         SCAN: begin
            if (tmr_num >= c_tmr_limit) begin
               w_expire     = 1'b1;
               w_state_next = DONE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign w_shift_en = (r_state == SCAN) && din_vld;
   assign busy       = (r_state == ARM) || (r_state == SCAN);

   seq_shift_match #(
      .PAT_W   (PAT_W),
      .PATTERN (PATTERN)
   ) u_shift_match (
      .clk      (clk),
      .rst      (rst),
      .clr      (w_launch),
      .shift_en (w_shift_en),
      .din      (din),
      .match    (w_match)
   );

   // The verdict uses the post-increment count so a match in the expiry cycle counts.
   assign w_hits_next = w_match ? sat_inc4(win_hits) : win_hits;

   always_ff @(posedge clk) begin
      if (rst) begin
         tmr_start <= 1'b0;
         hit       <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         win_hits  <= 4'd0;
      end else begin
         tmr_start <= w_launch;
         hit       <= w_match;
         done      <= w_expire;
         win_hits  <= w_launch ? 4'd0 : w_hits_next;
         if (w_expire) pass <= (w_hits_next >= c_hit_min);
      end
   end

endmodule

`default_nettype wire
